// File: rtl/call_stack_unit_pkg.sv
// Shared CPU definitions for the call/return stack.
// Word width, fault codes and stack FSM states.
package call_stack_unit_pkg;

  localparam int DATA_W = 19;

  localparam logic [1:0] FC_NONE     = 2'b00;
  localparam logic [1:0] FC_OVF      = 2'b01;
  localparam logic [1:0] FC_UNF      = 2'b10;
  localparam logic [1:0] FC_CONFLICT = 2'b11;

  typedef enum logic {
    NORMAL = 1'b0,
    FAULT  = 1'b1
  } cs_state_e;

endpackage

// File: rtl/call_stack_unit_lifo_mem.sv
// Stack storage: synchronous write, asynchronous indexed read.
// Contents are not reset; sp tracks which entries are live.
module call_stack_unit_lifo_mem #(
  parameter int DATA_W = 19,
  parameter int DEPTH  = 8,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     wr_idx_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [AW-1:0]     rd_idx_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_idx_i];

endmodule

// File: rtl/call_stack_unit.sv
// Execute-stage LIFO for push/pop/ret with overflow,
// underflow and conflict faults; cleared only by rst.
module call_stack_unit
  import call_stack_unit_pkg::*;
#(
  parameter  int DATA_W = call_stack_unit_pkg::DATA_W,
  parameter  int DEPTH  = 8,
  localparam int SP_W   = $clog2(DEPTH + 1),
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hazard,
  input  logic              push,
  input  logic              pop,
  input  logic              ret,
  input  logic [DATA_W-1:0] push_data,
  output logic [DATA_W-1:0] pop_data,
  output logic              pop_valid,
  output logic [DATA_W-1:0] ret_addr,
  output logic              ret_valid,
  output logic [SP_W-1:0]   sp,
  output logic              empty,
  output logic              full,
  output logic              fault,
  output logic [1:0]        fault_code
);

  cs_state_e         state_q, state_d;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic [DATA_W-1:0] pop_data_q, pop_data_d;
  logic [DATA_W-1:0] ret_addr_q, ret_addr_d;
  logic              pop_valid_q, pop_valid_d;
  logic              ret_valid_q, ret_valid_d;
  logic [1:0]        fc_q, fc_d;

  logic [2:0]        req;
  logic              is_push, is_pop, is_ret, is_multi;
  logic              we;
  logic [AW-1:0]     wr_idx, rd_idx;
  logic [DATA_W-1:0] top_word;
  logic              sp_empty, sp_full;

  assign req      = {push, pop, ret} & {3{~hazard}};
  assign is_push  = (req == 3'b100);
  assign is_pop   = (req == 3'b010);
  assign is_ret   = (req == 3'b001);
  assign is_multi = ($countones(req) > 1);

  assign sp_empty = (sp_q == '0);
  assign sp_full  = (sp_q == SP_W'(DEPTH));

  // Index truncation is safe: write is gated by !full, read by !empty.
  assign wr_idx = AW'(sp_q);
  assign rd_idx = AW'(sp_q - SP_W'(1));

  call_stack_unit_lifo_mem #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk      (clk),
    .we_i     (we),
    .wr_idx_i (wr_idx),
    .wr_data_i(push_data),
    .rd_idx_i (rd_idx),
    .rd_data_o(top_word)
  );

  always_comb begin
    state_d     = state_q;
    sp_d        = sp_q;
    pop_data_d  = pop_data_q;
    ret_addr_d  = ret_addr_q;
    pop_valid_d = 1'b0;
    ret_valid_d = 1'b0;
    fc_d        = fc_q;
    we          = 1'b0;
    if (state_q == NORMAL) begin
      unique case (1'b1)
        is_multi: begin
          state_d = FAULT;
          fc_d    = FC_CONFLICT;
        end
        is_push: begin
          if (sp_full) begin
            state_d = FAULT;
            fc_d    = FC_OVF;
          end else begin
            we   = 1'b1;
            sp_d = sp_q + SP_W'(1);
          end
        end
        is_pop: begin
          if (sp_empty) begin
            state_d = FAULT;
            fc_d    = FC_UNF;
          end else begin
            pop_data_d  = top_word;
            pop_valid_d = 1'b1;
            sp_d        = sp_q - SP_W'(1);
          end
        end
        is_ret: begin
          if (sp_empty) begin
            state_d = FAULT;
            fc_d    = FC_UNF;
          end else begin
            ret_addr_d  = top_word;
            ret_valid_d = 1'b1;
            sp_d        = sp_q - SP_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= NORMAL;
      sp_q        <= '0;
      pop_data_q  <= '0;
      ret_addr_q  <= '0;
      pop_valid_q <= 1'b0;
      ret_valid_q <= 1'b0;
      fc_q        <= FC_NONE;
    end else begin
      state_q     <= state_d;
      sp_q        <= sp_d;
      pop_data_q  <= pop_data_d;
      ret_addr_q  <= ret_addr_d;
      pop_valid_q <= pop_valid_d;
      ret_valid_q <= ret_valid_d;
      fc_q        <= fc_d;
    end
  end

  assign pop_data   = pop_data_q;
  assign pop_valid  = pop_valid_q;
  assign ret_addr   = ret_addr_q;
  assign ret_valid  = ret_valid_q;
  assign sp         = sp_q;
  assign empty      = sp_empty;
  assign full       = sp_full;
  assign fault      = (state_q == FAULT);
  assign fault_code = fc_q;

endmodule

// File: tb/tb_call_stack_unit.sv
// Bench for call_stack_unit: queue-based stack model checked
// every cycle, plus directed literal expectations.
module tb_call_stack_unit;

  localparam int DW    = 19;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          hazard = 1'b0;
  logic          push = 1'b0;
  logic          pop = 1'b0;
  logic          ret = 1'b0;
  logic [DW-1:0] push_data = '0;
  logic [DW-1:0] pop_data;
  logic          pop_valid;
  logic [DW-1:0] ret_addr;
  logic          ret_valid;
  logic [3:0]    sp;
  logic          empty;
  logic          full;
  logic          fault;
  logic [1:0]    fault_code;

  int checks = 0;
  int failures = 0;
  bit armed = 1'b0;

  call_stack_unit dut (
    .clk       (clk),
    .rst       (rst),
    .hazard    (hazard),
    .push      (push),
    .pop       (pop),
    .ret       (ret),
    .push_data (push_data),
    .pop_data  (pop_data),
    .pop_valid (pop_valid),
    .ret_addr  (ret_addr),
    .ret_valid (ret_valid),
    .sp        (sp),
    .empty     (empty),
    .full      (full),
    .fault     (fault),
    .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  // Reference model: a queue as the stack, plus fault flag/code.
  logic [DW-1:0] stk[$];
  bit            m_fault = 1'b0;
  int            m_code = 0;
  logic [DW-1:0] m_pd = '0;
  logic [DW-1:0] m_ra = '0;
  bit            m_pv = 1'b0;
  bit            m_rv = 1'b0;

  always @(posedge clk) begin
    int n;
    m_pv = 1'b0;
    m_rv = 1'b0;
    n = int'(push) + int'(pop) + int'(ret);
    if (rst) begin
      stk.delete();
      m_fault = 1'b0;
      m_code = 0;
      m_pd = '0;
      m_ra = '0;
    end else if (!hazard && !m_fault && n > 0) begin
      if (n > 1) begin
        m_fault = 1'b1;
        m_code = 3;
      end else if (push) begin
        if (stk.size() == DEPTH) begin
          m_fault = 1'b1;
          m_code = 1;
        end else stk.push_back(push_data);
      end else if (stk.size() == 0) begin
        m_fault = 1'b1;
        m_code = 2;
      end else if (pop) begin
        m_pd = stk.pop_back();
        m_pv = 1'b1;
      end else begin
        m_ra = stk.pop_back();
        m_rv = 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      chk("m_sp", 32'(sp), 32'(stk.size()));
      chk("m_empty", 32'(empty), 32'(stk.size() == 0));
      chk("m_full", 32'(full), 32'(stk.size() == DEPTH));
      chk("m_fault", 32'(fault), 32'(m_fault));
      chk("m_code", 32'(fault_code), 32'(m_code));
      chk("m_pv", 32'(pop_valid), 32'(m_pv));
      chk("m_rv", 32'(ret_valid), 32'(m_rv));
      chk("m_pd", 32'(pop_data), 32'(m_pd));
      chk("m_ra", 32'(ret_addr), 32'(m_ra));
    end
  end

  task automatic cyc(input logic r, input logic h, input logic pu,
                     input logic po, input logic rt,
                     input logic [DW-1:0] d);
    rst = r; hazard = h; push = pu; pop = po; ret = rt;
    push_data = d;
    @(posedge clk);
    #1;
    rst = 1'b0; hazard = 1'b0; push = 1'b0; pop = 1'b0; ret = 1'b0;
  endtask

  task automatic do_rst();  cyc(1, 0, 0, 0, 0, '0); endtask
  task automatic do_idle(); cyc(0, 0, 0, 0, 0, '0); endtask
  task automatic do_push(input logic [DW-1:0] d); cyc(0, 0, 1, 0, 0, d); endtask
  task automatic do_pop();  cyc(0, 0, 0, 1, 0, '0); endtask
  task automatic do_ret();  cyc(0, 0, 0, 0, 1, '0); endtask

  initial begin
    logic [DW-1:0] vals [3];
    vals[0] = 19'h00011; vals[1] = 19'h00022; vals[2] = 19'h7FFFF;

    do_rst();
    do_rst();
    armed = 1'b1;
    chk("rst_sp", 32'(sp), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_fault", 32'(fault), 0);
    chk("rst_pd", 32'(pop_data), 0);

    for (int i = 0; i < 3; i++) do_push(vals[i]);
    chk("push3_sp", 32'(sp), 3);
    for (int i = 2; i >= 0; i--) begin
      do_pop();
      chk("pop_data", 32'(pop_data), 32'(vals[i]));
      chk("pop_valid", 32'(pop_valid), 1);
      chk("pop_sp", 32'(sp), 32'(i));
    end
    chk("pop_empty", 32'(empty), 1);
    do_idle();
    chk("pd_hold", 32'(pop_data), 32'h00011);
    chk("pv_low", 32'(pop_valid), 0);

    for (int i = 1; i <= 8; i++) do_push(DW'(i));
    chk("full", 32'(full), 1);
    chk("full_sp", 32'(sp), 8);
    do_push(19'd9);
    chk("ovf_fault", 32'(fault), 1);
    chk("ovf_code", 32'(fault_code), 1);
    chk("ovf_sp", 32'(sp), 8);
    do_pop();
    chk("flt_pv", 32'(pop_valid), 0);
    chk("flt_sp", 32'(sp), 8);

    do_rst();
    do_ret();
    chk("unf_fault", 32'(fault), 1);
    chk("unf_code", 32'(fault_code), 2);
    chk("unf_rv", 32'(ret_valid), 0);
    do_rst();
    chk("clr_fault", 32'(fault), 0);
    chk("clr_code", 32'(fault_code), 0);
    chk("clr_sp", 32'(sp), 0);

    do_push(19'h00123);
    do_ret();
    chk("ret_addr", 32'(ret_addr), 32'h00123);
    chk("ret_valid", 32'(ret_valid), 1);
    chk("ret_pv", 32'(pop_valid), 0);
    chk("ret_sp", 32'(sp), 0);
    do_idle();
    chk("ret_1cyc", 32'(ret_valid), 0);

    cyc(0, 1, 1, 0, 0, 19'h00005);
    chk("hz_push_sp", 32'(sp), 0);
    do_push(19'h00006);
    cyc(0, 1, 0, 1, 0, '0);
    chk("hz_pv", 32'(pop_valid), 0);
    cyc(0, 1, 0, 1, 0, '0);
    chk("hz_sp", 32'(sp), 1);
    do_pop();
    chk("hz_pd", 32'(pop_data), 32'h00006);
    chk("hz_pv2", 32'(pop_valid), 1);

    do_push(19'h00055);
    do_pop();
    chk("b2b_pd", 32'(pop_data), 32'h00055);

    do_push(19'h0000A);
    do_push(19'h0000B);
    cyc(0, 0, 1, 1, 0, 19'h0000C);
    chk("cf_fault", 32'(fault), 1);
    chk("cf_code", 32'(fault_code), 3);
    chk("cf_sp", 32'(sp), 2);
    chk("cf_pv", 32'(pop_valid), 0);
    cyc(1, 0, 1, 0, 0, 19'h0000D);
    chk("rstpush_sp", 32'(sp), 0);
    chk("rstpush_flt", 32'(fault), 0);
    do_pop();
    chk("rstpush_unf", 32'(fault_code), 2);
    do_idle();

    armed = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
